shot_trajectory: RTL and testbench
==================================

SHOT_TRAJECTORY -- requirements
Module: shot_trajectory

Interface
REQ-001 SHALL have parameter START_X, default 80, launch x position in pixels.
REQ-002 SHALL have parameter START_Y, default 400, launch y position in pixels (y grows downward).
REQ-003 SHALL have parameter FLOOR_Y, default 460, miss line in pixels.
REQ-004 SHALL have parameter HOOP_X_MIN / HOOP_X_MAX, default 500 / 540, hoop opening x bounds, inclusive.
REQ-005 SHALL have parameter HOOP_Y, default 200, hoop rim y.
REQ-006 SHALL have parameter RESULT_FRAMES, default 60, frames to hold SCORED/MISS.
REQ-007 SHALL have port clk, input, 1, single 25 MHz pixel clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port frame_tick, input, 1, one-cycle pulse per frame from the sync generator at the start of vertical blanking.
REQ-010 SHALL have port launch_btn, input, 1, raw asynchronous push-button level.
REQ-011 SHALL have port sw, input, 3, launch-velocity select.
REQ-012 SHALL have port ball_x, output, 10, ball centre x, integer pixels.
REQ-013 SHALL have port ball_y, output, 10, ball centre y, integer pixels.
REQ-014 SHALL have port state, output, 2, IDLE=0, FLIGHT=1, SCORED=2, MISS=3.
REQ-015 SHALL have port score, output, 4, made-shot count.

Function
REQ-016 Internal position and velocity SHALL be signed fixed point, 4 fraction bits: position 11.4 (signed 15 bits), velocity 6.4 (signed 10 bits); ball_x/ball_y are the integer part, bits [13:4].
REQ-017 launch_btn SHALL pass a 2-flop synchroniser; a launch is a single-cycle rising edge of the synchronised level.
REQ-018 IDLE: ball held at (START_X, START_Y). On a launch, go to FLIGHT and load vx/vy from table entry sw, sampled in the same cycle.
REQ-019 Launches outside IDLE SHALL be ignored; a held button SHALL NOT relaunch.
REQ-020 FLIGHT, on each frame_tick: x += vx; y += vy; vy += G, with G = 0.25 px/frame^2 (4 LSB). Position updates use the old velocity. Results are registered one clk after frame_tick.
REQ-021 A launch and a frame_tick in the same cycle SHALL only launch; the first physics step is on the next frame_tick.
REQ-022 Score check on each update: old y < HOOP_Y, new y >= HOOP_Y, vy > 0 and HOOP_X_MIN <= new x <= HOOP_X_MAX -> SCORED, score += 1.
REQ-023 Miss check: new y >= FLOOR_Y, new x > 639 or new x < 0 -> MISS. The score check has priority when both hold.
REQ-024 ball_x/ball_y SHALL saturate to 0..639 / 0..479; there is no wrap-around.
REQ-025 SCORED/MISS: the ball freezes. After RESULT_FRAMES frame_ticks, return to IDLE with the ball at the start position.
REQ-026 score SHALL wrap from 15 to 0.

Reset
REQ-027 Reset low, at any time including mid-flight, SHALL asynchronously force state=IDLE, ball_x=START_X, ball_y=START_Y, velocities 0, result counter 0, score 0, synchroniser flops 0.
REQ-028 Reset deassertion is synchronised externally; the first launch is accepted 2 clk after a rising button edge.

Configuration
REQ-029 Macro SHOT_SCORE_COUNTER_EN defined: score counter per REQ-022/REQ-026.
REQ-030 Macro SHOT_SCORE_COUNTER_EN undefined: no score register; score is tied to 4'd0; state behaviour is unchanged.

Structure
REQ-031 Package shot_pkg SHALL hold the state encoding, fixed-point widths, G, and the 8-entry velocity table {vx, vy}. Entry 0 = (+3.0, -8.0). Entry 7 is tuned so that a shot from the default parameters scores.
REQ-032 Sub-module btn_sync (2-flop synchroniser + rising-edge detect) SHALL be instantiated once.

Verification
REQ-033 Reset asserted mid-FLIGHT -> immediately state=0, ball=(80,400), score=0.
REQ-034 sw=0, launch, one frame_tick -> state=1, ball=(83,392). Second tick -> (86,384).
REQ-035 sw=0 flight to completion -> ball never enters the hoop window, ends state=3 with ball_y=460 clamp region; after 60 ticks state=0 at (80,400).
REQ-036 sw=7 flight -> state=2 on the hoop-crossing frame; score goes 0->1; a second identical shot gives score=2.
REQ-037 Button held through FLIGHT and re-pressed in MISS -> no relaunch; a launch coinciding with frame_tick in IDLE -> ball still (80,400) until the next tick.
REQ-038 Build without SHOT_SCORE_COUNTER_EN, repeat REQ-036 -> state=2 reached, score stays 0.

Source files
------------

// File: rtl/shot_pkg.sv
// Shared constants for the shot trajectory block: state codes,
// fixed-point formats, gravity and the launch velocity table.
package shot_pkg;

    localparam int FRAC  = 4;
    localparam int POS_W = 15;
    localparam int VEL_W = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLIGHT = 2'd1;
    localparam logic [1:0] ST_SCORED = 2'd2;
    localparam logic [1:0] ST_MISS   = 2'd3;

    typedef logic signed [POS_W-1:0] pos_t;
    typedef logic signed [VEL_W-1:0] vel_t;

    typedef struct packed {
        vel_t vx;
        vel_t vy;
    } launch_vel_t;

    // 0.25 px/frame^2 in 6.4 format
    localparam vel_t GRAV = 10'sd4;

    // Entry 7 crosses the rim at x=517 on frame 76 from (80,400)
    function automatic launch_vel_t vel_table(input logic [2:0] sel);
        launch_vel_t v;
        v.vx = 10'sd0;
        v.vy = 10'sd0;
        case (sel)
            3'd0: begin v.vx = 10'sd48;  v.vy = -10'sd128; end
            3'd1: begin v.vx = 10'sd32;  v.vy = -10'sd96;  end
            3'd2: begin v.vx = 10'sd64;  v.vy = -10'sd144; end
            3'd3: begin v.vx = 10'sd80;  v.vy = -10'sd160; end
            3'd4: begin v.vx = 10'sd96;  v.vy = -10'sd176; end
            3'd5: begin v.vx = 10'sd128; v.vy = -10'sd112; end
            3'd6: begin v.vx = -10'sd32; v.vy = -10'sd128; end
            default: begin v.vx = 10'sd92; v.vy = -10'sd192; end
        endcase
        return v;
    endfunction

endpackage

// File: rtl/shot_trajectory_btn_sync.sv
// Two-flop synchroniser for the raw launch button plus a
// rising-edge detector producing a single-cycle pulse.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/shot_trajectory.sv
// Basketball shot physics: per-frame ballistic update, hoop/miss detection.
// Optional made-shot counter enabled by SHOT_SCORE_COUNTER_EN.
module shot_trajectory
    import shot_pkg::*;
#(
    parameter int START_X       = 80,
    parameter int START_Y       = 400,
    parameter int FLOOR_Y       = 460,
    parameter int HOOP_X_MIN    = 500,
    parameter int HOOP_X_MAX    = 540,
    parameter int HOOP_Y        = 200,
    parameter int RESULT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       launch_btn,
    input  logic [2:0] sw,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] state,
    output logic [3:0] score
);

    localparam pos_t X0      = pos_t'(START_X * 16);
    localparam pos_t Y0      = pos_t'(START_Y * 16);
    localparam pos_t FLOOR   = pos_t'(FLOOR_Y * 16);
    localparam pos_t RIM_Y   = pos_t'(HOOP_Y * 16);
    localparam pos_t RIM_X0  = pos_t'(HOOP_X_MIN * 16);
    localparam pos_t RIM_X1  = pos_t'((HOOP_X_MAX + 1) * 16);
    localparam pos_t SCR_X   = pos_t'(640 * 16);
    localparam pos_t SCR_Y   = pos_t'(480 * 16);
    localparam logic [15:0] LAST = 16'(RESULT_FRAMES - 1);

    logic        launch;
    logic [1:0]  st_q;
    pos_t        x_q;
    pos_t        y_q;
    vel_t        vx_q;
    vel_t        vy_q;
    logic [15:0] cnt_q;

    pos_t        nx;
    pos_t        ny;
    vel_t        nvy;
    logic        hit;
    logic        miss;
    launch_vel_t tbl;

    btn_sync u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (launch_btn),
        .rise  (launch)
    );

    assign tbl = vel_table(sw);
    assign nx  = x_q + {{(POS_W-VEL_W){vx_q[VEL_W-1]}}, vx_q};
    assign ny  = y_q + {{(POS_W-VEL_W){vy_q[VEL_W-1]}}, vy_q};
    assign nvy = vy_q + GRAV;

    assign hit = (y_q < RIM_Y) && (ny >= RIM_Y)
              && !vy_q[VEL_W-1] && (vy_q != '0)
              && (nx >= RIM_X0) && (nx < RIM_X1);

    assign miss = (ny >= FLOOR) || (nx >= SCR_X) || nx[POS_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= ST_IDLE;
            x_q   <= X0;
            y_q   <= Y0;
            vx_q  <= '0;
            vy_q  <= '0;
            cnt_q <= '0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (launch) begin
                        st_q <= ST_FLIGHT;
                        vx_q <= tbl.vx;
                        vy_q <= tbl.vy;
                    end
                end
                ST_FLIGHT: begin
                    if (frame_tick) begin
                        x_q  <= nx;
                        y_q  <= ny;
                        vy_q <= nvy;
                        if (hit)
                            st_q <= ST_SCORED;
                        else if (miss)
                            st_q <= ST_MISS;
                    end
                end
                default: begin
                    if (frame_tick) begin
                        if (cnt_q == LAST) begin
                            st_q  <= ST_IDLE;
                            cnt_q <= '0;
                            x_q   <= X0;
                            y_q   <= Y0;
                            vx_q  <= '0;
                            vy_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef SHOT_SCORE_COUNTER_EN
    logic [3:0] score_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            score_q <= '0;
        else if (st_q == ST_FLIGHT && frame_tick && hit)
            score_q <= score_q + 4'd1;
    end

    assign score = score_q;
`else
    assign score = 4'd0;
`endif

    // Ball may leave the screen before the miss registers; clamp, never wrap
    assign ball_x = x_q[POS_W-1] ? 10'd0 :
                    (x_q >= SCR_X) ? 10'd639 : x_q[13:4];
    assign ball_y = y_q[POS_W-1] ? 10'd0 :
                    (y_q >= SCR_Y) ? 10'd479 : y_q[13:4];
    assign state  = st_q;

endmodule

// File: tb/tb_shot_trajectory.sv
// Directed + randomized bench for shot_trajectory against a
// closed-form ballistic reference model.
module tb_shot_trajectory;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       launch_btn = 1'b0;
    logic [2:0] sw = 3'd0;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [1:0] state;
    logic [3:0] score;

    int n_pass = 0;
    int n_total = 0;

    // reference model: positions in 1/16 px
    int tvx [8] = '{48, 32, 64, 80, 96, 128, -32, 92};
    int tvy [8] = '{-128, -96, -144, -160, -176, -112, -128, -192};
    int m_state, m_n, m_vx, m_vy, m_cnt, m_score, m_px, m_py;
    bit saw_scored;

    shot_trajectory dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .launch_btn (launch_btn),
        .sw         (sw),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .state      (state),
        .score      (score)
    );

    always #20 clk = ~clk;

    function automatic int pos_x(int n);
        return 80 * 16 + n * m_vx;
    endfunction

    function automatic int pos_y(int n);
        return 400 * 16 + n * m_vy + 2 * n * (n - 1);
    endfunction

    function automatic int sat(int v, int mx);
        if (v < 0) return 0;
        if (v / 16 > mx) return mx;
        return v / 16;
    endfunction

    task automatic model_reset();
        m_state = 0; m_n = 0; m_vx = 0; m_vy = 0;
        m_cnt = 0; m_score = 0;
        m_px = 80 * 16; m_py = 400 * 16;
    endtask

    task automatic model_tick();
        int xn, yn, yo, vyo;
        if (m_state == 1) begin
            m_n = m_n + 1;
            xn  = pos_x(m_n);
            yn  = pos_y(m_n);
            yo  = pos_y(m_n - 1);
            vyo = m_vy + 4 * (m_n - 1);
            m_px = xn;
            m_py = yn;
            if (yo < 3200 && yn >= 3200 && vyo > 0 &&
                xn >= 500 * 16 && xn < 541 * 16) begin
                m_state = 2;
                saw_scored = 1'b1;
`ifdef SHOT_SCORE_COUNTER_EN
                m_score = (m_score + 1) % 16;
`endif
            end else if (yn >= 460 * 16 || xn >= 640 * 16 || xn < 0) begin
                m_state = 3;
            end
        end else if (m_state >= 2) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 60) begin
                m_state = 0; m_cnt = 0; m_n = 0;
                m_px = 80 * 16; m_py = 400 * 16;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(string tag);
        check({tag, ".state"}, 32'(state), m_state);
        check({tag, ".x"}, 32'(ball_x), sat(m_px, 639));
        check({tag, ".y"}, 32'(ball_y), sat(m_py, 479));
        check({tag, ".score"}, 32'(score), m_score);
    endtask

    task automatic frame(string tag);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        model_tick();
        check_all(tag);
    endtask

    task automatic model_launch(int s);
        if (m_state == 0) begin
            m_state = 1; m_n = 0;
            m_vx = tvx[s]; m_vy = tvy[s];
        end
    endtask

    task automatic press(int s);
        sw = 3'(s);
        @(negedge clk) launch_btn = 1'b1;
        repeat (4) @(negedge clk);
        launch_btn = 1'b0;
        repeat (3) @(negedge clk);
        model_launch(s);
        check_all("launch");
    endtask

    task automatic finish_shot(string tag);
        int k;
        k = 0;
        while (m_state == 1 && k < 300) begin
            frame(tag);
            k++;
        end
        check({tag, ".flight_ended"}, 32'(k < 300), 1);
        k = 0;
        while (m_state != 0 && k < 100) begin
            frame({tag, ".result"});
            k++;
        end
        check({tag, ".back_idle"}, 32'(state), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // launch coinciding with frame_tick: only launches
        sw = 3'd0;
        launch_btn = 1'b1;
        @(negedge clk);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        model_launch(0);
        check_all("coincide");
        frame("sw0.f1");
        check("sw0.f1.x", 32'(ball_x), 83);
        check("sw0.f1.y", 32'(ball_y), 392);
        frame("sw0.f2");
        check("sw0.f2.x", 32'(ball_x), 86);
        check("sw0.f2.y", 32'(ball_y), 384);
        saw_scored = 1'b0;
        begin
            int k;
            k = 0;
            while (m_state == 1 && k < 300) begin
                frame("sw0");
                k++;
            end
        end
        check("sw0.miss", 32'(state), 3);
        check("sw0.no_score", 32'(saw_scored), 0);
        check("sw0.floor", 32'(ball_y >= 10'd460), 1);
        // release and re-press while in MISS: no relaunch
        launch_btn = 1'b0;
        repeat (4) @(negedge clk);
        launch_btn = 1'b1;
        repeat (5) @(negedge clk);
        launch_btn = 1'b0;
        repeat (3) @(negedge clk);
        check_all("repress");
        finish_shot("sw0");
        check("sw0.home.x", 32'(ball_x), 80);
        check("sw0.home.y", 32'(ball_y), 400);

        // two scoring shots
        for (int i = 0; i < 2; i++) begin
            saw_scored = 1'b0;
            press(7);
            finish_shot("sw7");
            check("sw7.scored", 32'(saw_scored), 1);
        end

        // randomized shots
        for (int i = 0; i < 4; i++) begin
            press(int'($urandom_range(0, 7)));
            finish_shot("rand");
        end

        // reset mid-flight
        press(7);
        repeat (10) frame("pre_rst");
        @(negedge clk);
        #3 reset = 1'b0;
        #1 model_reset();
        check_all("rst_mid");
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
